// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic master.
// Holds the FSM state type, request size encodings, cycle type identifier
// constants and an alignment check used when a request is accepted.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CYCLE,
    S_BACKOFF,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // True when the request must be rejected without a bus cycle:
  // misaligned half/word, or the reserved size encoding.
  function automatic logic bad_request(input logic [1:0] size,
                                       input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte lane steering for the Wishbone master (purely combinational).
//   size, addr_lo : access size and byte offset within the word
//   uns           : zero-extend loads when 1, sign-extend when 0
//   wdata         : right-aligned store data
//   dat_i         : raw 32-bit read data from the bus
//   sel           : byte lane enables
//   wdata_rep     : store data replicated across lanes
//   rdata_ext     : selected lane(s) right-aligned and extended
module wb_lane_align
  import wb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    sel       = '0;
    wdata_rep = wdata;
    rdata_ext = '0;
    shifted   = dat_i >> {addr_lo, 3'b000};
    case (size)
      SZ_B: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'h0, shifted[7:0]}
                        : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        sel       = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'h0, shifted[15:0]}
                        : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = dat_i;
      end
      default: begin
        sel       = '0;
        wdata_rep = wdata;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/wb_master.sv
// Single-request Wishbone classic master.
// Accepts one load/store from the core, runs a classic bus cycle with
// retry/backoff and timeout handling, then returns a one-cycle response.
//   clk, rst                : clock, asynchronous active-high reset
//   req_*                   : core request (valid/ready handshake)
//   resp_*                  : one-cycle completion pulse, data, error flag
//   CYC/STB/WE/ADR/DAT_O/SEL/CTI_O : Wishbone master outputs
//   DAT_I/ACK/ERR/RTY       : Wishbone slave inputs
module wb_master
  import wb_pkg::*;
#(
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        CYC,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic [3:0]  SEL,
  output logic [2:0]  CTI_O,
  input  logic        ACK,
  input  logic        ERR,
  input  logic        RTY
);

  localparam int RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    lat_size;
  logic [1:0]    lat_lo;
  logic          lat_uns;
  logic          lat_we;

  logic [1:0]    al_size;
  logic [1:0]    al_lo;
  logic [3:0]    al_sel;
  logic [31:0]   al_wdata;
  logic [31:0]   al_rdata;

  // One aligner serves both acceptance (live request fields) and the
  // rest of the transaction (latched fields).
  assign al_size = (state == S_IDLE) ? req_size    : lat_size;
  assign al_lo   = (state == S_IDLE) ? req_addr[1:0] : lat_lo;

  wb_lane_align u_align (
    .size      (al_size),
    .addr_lo   (al_lo),
    .uns       (lat_uns),
    .wdata     (req_wdata),
    .dat_i     (DAT_I),
    .sel       (al_sel),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  assign req_ready = (state == S_IDLE);
  assign CTI_O     = CTI_CLASSIC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      lat_size   <= '0;
      lat_lo     <= '0;
      lat_uns    <= 1'b0;
      lat_we     <= 1'b0;
      CYC        <= 1'b0;
      STB        <= 1'b0;
      WE         <= 1'b0;
      ADR        <= '0;
      DAT_O      <= '0;
      SEL        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_size <= req_size;
            lat_lo   <= req_addr[1:0];
            lat_uns  <= req_unsigned;
            lat_we   <= req_we;
            if (bad_request(req_size, req_addr[1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state   <= S_CYCLE;
              tmo_cnt <= '0;
              CYC     <= 1'b1;
              STB     <= 1'b1;
              WE      <= req_we;
              ADR     <= {req_addr[31:2], 2'b00};
              DAT_O   <= al_wdata;
              SEL     <= al_sel;
            end
          end
        end
        S_CYCLE: begin
          if (ERR || (RTY && retry_cnt == RW'(MAX_RETRY))) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; SEL <= '0;
          end else if (RTY) begin
            state     <= S_BACKOFF;
            retry_cnt <= retry_cnt + RW'(1);
            CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; SEL <= '0;
          end else if (ACK) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= lat_we ? '0 : al_rdata;
            CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; SEL <= '0;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            CYC <= 1'b0; STB <= 1'b0; WE <= 1'b0; SEL <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_BACKOFF: begin
          // ADR and DAT_O were held through the gap; only the strobes return.
          state   <= S_CYCLE;
          tmo_cnt <= '0;
          CYC     <= 1'b1;
          STB     <= 1'b1;
          WE      <= lat_we;
          SEL     <= al_sel;
        end
        S_RESP: begin
          state     <= S_IDLE;
          retry_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master.sv
module tb_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        CYC, STB, WE;
  logic [31:0] ADR, DAT_O, DAT_I;
  logic [3:0]  SEL;
  logic [2:0]  CTI_O;
  logic        ACK, ERR, RTY;

  int n_chk = 0;
  int n_bad = 0;

  // slave model controls
  logic        silent = 1'b0;
  logic        err_mode = 1'b0;
  int          rty_left = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  wb_master #(.MAX_RETRY(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .SEL(SEL), .CTI_O(CTI_O), .ACK(ACK), .ERR(ERR), .RTY(RTY)
  );

  assign DAT_I = mem[ADR[5:2]];
  assign ERR = CYC & STB & err_mode & ~silent;
  assign RTY = CYC & STB & ~err_mode & ~silent & (rty_left != 0);
  assign ACK = CYC & STB & ~err_mode & ~silent & (rty_left == 0);

  always @(posedge clk) begin
    if (RTY) rty_left <= rty_left - 1;
    if (ACK && WE)
      for (int i = 0; i < 4; i++)
        if (SEL[i]) mem[ADR[5:2]][8*i +: 8] <= DAT_O[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // results of the last transaction
  int          r_lat, r_gaps, r_cycn;
  logic        r_done, r_err;
  logic [31:0] r_rdata, s_dat, s_adr;
  logic [3:0]  s_sel;
  logic        s_we;

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [1:0] sz, input logic u);
    int w;
    bit seen;
    w = 0;
    seen = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    req_addr = a; req_wdata = d; req_we = we; req_size = sz; req_unsigned = u;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0; r_gaps = 0; r_cycn = 0; r_done = 0; r_err = 0; r_rdata = '0;
    s_dat = '0; s_adr = '0; s_sel = '0; s_we = 0;
    while (!r_done && r_lat < 400) begin
      @(negedge clk);
      r_lat++;
      if (CYC) begin
        if (!seen) begin s_dat = DAT_O; s_adr = ADR; s_sel = SEL; s_we = WE; end
        seen = 1;
        r_cycn++;
      end else if (seen && !resp_valid) begin
        r_gaps++;
      end
      if (resp_valid) begin
        r_done = 1; r_err = resp_err; r_rdata = resp_rdata;
      end
    end
  endtask

  initial begin
    bit saw;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[4] = 32'h8000_00F0;

    // reset state
    #1;
    check("rst_cyc", 32'(CYC), 0);
    check("rst_sel", 32'(SEL), 0);
    check("rst_adr", ADR, 0);
    check("rst_dato", DAT_O, 0);
    check("rst_resp", 32'({resp_valid, resp_err}), 0);
    check("rst_ready", 32'(req_ready), 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // word load 0x10
    do_req(32'h10, 0, 0, 2'd2, 0);
    check("wl_done", 32'(r_done), 1);
    check("wl_lat", r_lat, 2);
    check("wl_data", r_rdata, 32'h8000_00F0);
    check("wl_err", 32'(r_err), 0);
    check("wl_adr", s_adr, 32'h10);
    check("wl_sel", 32'(s_sel), 32'hF);
    check("wl_cti", 32'(CTI_O), 0);

    // byte load signed / unsigned at 0x13
    do_req(32'h13, 0, 0, 2'd0, 0);
    check("lb_sel", 32'(s_sel), 32'h8);
    check("lb_data", r_rdata, 32'hFFFF_FF80);
    do_req(32'h13, 0, 0, 2'd0, 1);
    check("lbu_data", r_rdata, 32'h0000_0080);

    // half store 0xBEEF at 0x6, then read back
    do_req(32'h6, 32'h0000_BEEF, 1, 2'd1, 0);
    check("sh_sel", 32'(s_sel), 32'hC);
    check("sh_dato", s_dat, 32'hBEEF_BEEF);
    check("sh_we", 32'(s_we), 1);
    check("sh_rdata", r_rdata, 0);
    check("sh_err", 32'(r_err), 0);
    do_req(32'h4, 0, 0, 2'd2, 0);
    check("sh_rb", r_rdata, 32'hBEEF_0000);
    do_req(32'h6, 0, 0, 2'd1, 0);
    check("lh_data", r_rdata, 32'hFFFF_BEEF);

    // byte store 0xA5 at 0x9
    do_req(32'h9, 32'h1234_56A5, 1, 2'd0, 0);
    check("sb_sel", 32'(s_sel), 32'h2);
    check("sb_dato", s_dat, 32'hA5A5_A5A5);
    do_req(32'h8, 0, 0, 2'd2, 0);
    check("sb_rb", r_rdata, 32'h0000_A500);

    // three retries then ACK
    rty_left = 3;
    do_req(32'h10, 0, 0, 2'd2, 0);
    check("r3_gaps", r_gaps, 3);
    check("r3_err", 32'(r_err), 0);
    check("r3_lat", r_lat, 8);
    check("r3_data", r_rdata, 32'h8000_00F0);

    // five retries exhaust MAX_RETRY=4
    rty_left = 5;
    do_req(32'h10, 0, 0, 2'd2, 0);
    check("r5_err", 32'(r_err), 1);
    check("r5_gaps", r_gaps, 4);
    check("r5_cycn", r_cycn, 5);
    rty_left = 0;

    // bus error
    err_mode = 1'b1;
    do_req(32'h10, 0, 0, 2'd2, 0);
    check("be_err", 32'(r_err), 1);
    check("be_data", r_rdata, 0);
    err_mode = 1'b0;

    // misaligned word and illegal size: no bus cycle
    do_req(32'h2, 0, 0, 2'd2, 0);
    check("ma_lat", r_lat, 1);
    check("ma_err", 32'(r_err), 1);
    check("ma_cycn", r_cycn, 0);
    do_req(32'h0, 0, 0, 2'd3, 0);
    check("sz3_err", 32'(r_err), 1);
    check("sz3_cycn", r_cycn, 0);

    // silent slave timeout
    silent = 1'b1;
    do_req(32'h10, 0, 0, 2'd2, 0);
    check("to_done", 32'(r_done), 1);
    check("to_err", 32'(r_err), 1);
    check("to_cycn", r_cycn, 255);

    // reset mid-cycle
    @(negedge clk);
    req_addr = 32'h10; req_size = 2'd2; req_we = 0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_cyc_before", 32'(CYC), 1);
    #2 rst = 1'b1;
    #1;
    check("mr_cyc", 32'(CYC), 0);
    check("mr_stb", 32'(STB), 0);
    check("mr_sel", 32'(SEL), 0);
    check("mr_adr", ADR, 0);
    @(negedge clk);
    rst = 1'b0;
    silent = 1'b0;
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) saw = 1;
    end
    check("mr_noresp", 32'(saw), 0);
    check("mr_ready", 32'(req_ready), 1);

    // normal operation after reset
    do_req(32'h10, 0, 0, 2'd2, 0);
    check("post_data", r_rdata, 32'h8000_00F0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
